// File: rtl/prime_pacer.sv
// prime_pacer: buffers primes from the sieve reader in a small FIFO and
// releases one per 1-second tick into a serial double-dabble converter that
// produces six BCD digits for the 7-segment display.
//
// Optional build macro: PRIME_PACER_LZ_BLANK_EN
//   defined   -> digit_en blanks leading zero digits (digit 0 always lit)
//   undefined -> digit_en is 6'b111111, leading zeros are shown
//
// Handshake (input side): a value transfers on a rising clk edge where
// in_valid && in_ready. in_ready depends only on registered occupancy, never
// on in_valid, tick or pause, so a full FIFO refuses a push even in a cycle
// where it also pops.
module prime_pacer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     tick,
    input  logic                     pause,
    output logic [23:0]              bcd_out,
    output logic [5:0]               digit_en,
    output logic                     out_valid,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int CMP_W = DATA_W + 20;

`ifdef PRIME_PACER_LZ_BLANK_EN
    localparam logic [5:0] DEN_RST = 6'b000001;
`else
    localparam logic [5:0] DEN_RST = 6'b111111;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;

    logic              tick_q;
    logic              tick_evt;
    logic              push;
    logic              pop;
    logic              last_shift;

    logic [DATA_W-1:0] sh_val;
    logic [23:0]       sh_bcd;
    logic [23:0]       bcd_adj;
    logic [23:0]       result;
    logic              sh_ovf;
    logic [CNT_W-1:0]  sh_cnt;
    logic [5:0]        den_calc;

    assign in_ready   = (level_q != LVL_W'(DEPTH));
    assign fifo_level = level_q;
    assign tick_evt   = tick & ~tick_q;
    assign push       = in_valid & in_ready;
    assign last_shift = (sh_cnt == CNT_W'(DATA_W - 1));

    // Previous-cycle tick level for rising-edge detection; reset high so a
    // tick already high at reset release is not treated as an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b1;
        end else begin
            tick_q <= tick;
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Converter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and pop decision; ticks that cannot be served are dropped.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_evt && (level_q != '0) && !pause) begin
                    pop     = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Double-dabble add-3 step: every digit of 5 or more is bumped by 3.
    always_comb begin
        bcd_adj = sh_bcd;
        for (int i = 0; i < 6; i++) begin
            if (sh_bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = sh_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Final value shown: saturate to all nines when the popped value was too big.
    always_comb begin
        result = sh_ovf ? 24'h999999 : sh_bcd;
    end

    // Digit enables derived from the final value.
    always_comb begin
        den_calc = 6'b111111;
`ifdef PRIME_PACER_LZ_BLANK_EN
        for (int i = 1; i < 6; i++) begin
            den_calc[i] = ((result >> (4 * i)) != 24'd0);
        end
        den_calc[0] = 1'b1;
`endif
    end

    // Conversion datapath: load on pop, one adjust-and-shift per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_val <= '0;
            sh_bcd <= '0;
            sh_ovf <= 1'b0;
            sh_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        sh_val <= mem[rd_ptr];
                        sh_bcd <= '0;
                        sh_cnt <= '0;
                        sh_ovf <= (CMP_W'(mem[rd_ptr]) > CMP_W'(999999));
                    end
                end
                SHIFT: begin
                    sh_bcd <= {bcd_adj[22:0], sh_val[DATA_W-1]};
                    sh_val <= sh_val << 1;
                    sh_cnt <= sh_cnt + 1'b1;
                end
                default: begin
                    sh_cnt <= sh_cnt;
                end
            endcase
        end
    end

    // Display outputs: updated once from DONE, held otherwise; overflow is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_out   <= 24'd0;
            digit_en  <= DEN_RST;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= (state_q == DONE);
            if (state_q == DONE) begin
                bcd_out  <= result;
                digit_en <= den_calc;
                if (sh_ovf) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prime_pacer.sv
// Testbench for prime_pacer: a FIFO/pacing model predicts which ticks pop,
// expected display results are queued at the tick and compared when
// out_valid fires, including the exact output cycle.
module tb_prime_pacer;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 20;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

`ifdef PRIME_PACER_LZ_BLANK_EN
    localparam logic [5:0] DEN_RST = 6'b000001;
    localparam logic [5:0] DEN_97  = 6'b000011;
`else
    localparam logic [5:0] DEN_RST = 6'b111111;
    localparam logic [5:0] DEN_97  = 6'b111111;
`endif

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              tick;
    logic              pause;
    logic [23:0]       bcd_out;
    logic [5:0]        digit_en;
    logic              out_valid;
    logic              overflow;
    logic [LVL_W-1:0]  fifo_level;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ov_count = 0;

    // Model state
    logic [DATA_W-1:0] mdl_q[$];
    logic [23:0]       exp_q[$];
    logic [5:0]        exp_den_q[$];
    logic              exp_ovf_q[$];
    int                exp_cyc_q[$];
    logic              m_tick_prev;
    logic              m_ovf;
    int                busy_end;

    prime_pacer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tick       (tick),
        .pause      (pause),
        .bcd_out    (bcd_out),
        .digit_en   (digit_en),
        .out_valid  (out_valid),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned x;
        if (v > 999999) return 24'h999999;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [5:0] den_of(input logic [23:0] b);
        logic [5:0] d;
        d = 6'b111111;
`ifdef PRIME_PACER_LZ_BLANK_EN
        for (int i = 1; i < 6; i++) begin
            d[i] = 1'b0;
            for (int j = i; j < 6; j++) begin
                if (b[4*j +: 4] != 4'd0) d[i] = 1'b1;
            end
        end
`endif
        return d;
    endfunction

    // Scoreboard: compare every out_valid against the oldest expectation
    always @(negedge clk) begin
        if (out_valid) begin
            ov_count++;
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                check("bcd_out", bcd_out, exp_q.pop_front());
                check("digit_en", digit_en, exp_den_q.pop_front());
                check("overflow", overflow, exp_ovf_q.pop_front());
                check("out_valid_cycle", cyc, exp_cyc_q.pop_front());
            end
        end else if (exp_cyc_q.size() > 0 && cyc >= exp_cyc_q[0]) begin
            check("out_valid_missing", 32'd0, 32'd1);
            void'(exp_q.pop_front());
            void'(exp_den_q.pop_front());
            void'(exp_ovf_q.pop_front());
            void'(exp_cyc_q.pop_front());
        end
    end

    // Driver: one cycle of stimulus plus the model's prediction for it
    task automatic drive_cycle(input logic t, input logic pv, input logic [DATA_W-1:0] pd);
        logic evt;
        logic acc;
        logic [DATA_W-1:0] v;
        logic [23:0] b;
        tick     = t;
        in_valid = pv;
        in_data  = pd;
        evt = t && !m_tick_prev;
        acc = pv && (mdl_q.size() != DEPTH);
        if (pv) check("in_ready", in_ready, 32'(mdl_q.size() != DEPTH));
        if (evt && mdl_q.size() > 0 && cyc >= busy_end && !pause) begin
            v = mdl_q.pop_front();
            b = to_bcd(v);
            if (v > 999999) m_ovf = 1'b1;
            exp_q.push_back(b);
            exp_den_q.push_back(den_of(b));
            exp_ovf_q.push_back(m_ovf);
            exp_cyc_q.push_back(cyc + DATA_W + 2);
            busy_end = cyc + DATA_W + 2;
        end
        if (acc) mdl_q.push_back(pd);
        m_tick_prev = t;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, '0);
    endtask

    task automatic push_val(input logic [DATA_W-1:0] v);
        drive_cycle(1'b0, 1'b1, v);
    endtask

    task automatic tick_and_wait();
        drive_cycle(1'b1, 1'b0, '0);
        idle(29);
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        tick     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        pause    = 1'b0;
        mdl_q.delete();
        exp_q.delete();
        exp_den_q.delete();
        exp_ovf_q.delete();
        exp_cyc_q.delete();
        m_ovf    = 1'b0;
        busy_end = 0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        m_tick_prev = 1'b1;
    endtask

    // Watchdog
    initial begin
        #200000;
        check("watchdog_timeout", 32'd0, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    int snap;

    initial begin
        do_reset(3);
        check("rst_bcd_out", bcd_out, 24'd0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_digit_en", digit_en, DEN_RST);

        // Basic pacing: 2, 3, 5
        push_val(2); push_val(3); push_val(5);
        check("level_after_3", fifo_level, 3);
        tick_and_wait(); tick_and_wait(); tick_and_wait();
        check("level_drained", fifo_level, 0);

        // Pause, busy-discard, pause mid-conversion, simultaneous push/pop
        push_val(11); push_val(13);
        pause = 1'b1;
        drive_cycle(1'b1, 1'b0, '0);
        idle(5);
        check("paused_no_pop", fifo_level, 2);
        pause = 1'b0;
        drive_cycle(1'b1, 1'b0, '0);
        idle(4);
        drive_cycle(1'b1, 1'b0, '0);
        idle(3);
        check("busy_tick_dropped", fifo_level, 1);
        pause = 1'b1;
        idle(20);
        pause = 1'b0;
        drive_cycle(1'b1, 1'b1, 17);
        idle(1);
        check("push_pop_level", fifo_level, 1);
        idle(28);
        tick_and_wait();
        check("level_after_pp", fifo_level, 0);

        // Saturation and sticky overflow
        push_val(999983); push_val(1048575);
        tick_and_wait(); tick_and_wait();
        check("overflow_set", overflow, 1'b1);
        check("bcd_saturated", bcd_out, 24'h999999);
        push_val(7);
        tick_and_wait();
        check("overflow_sticky", overflow, 1'b1);

        // Leading-zero blanking on 97
        push_val(97);
        tick_and_wait();
        check("digit_en_97", digit_en, DEN_97);
        check("bcd_97", bcd_out, 24'h000097);

        // Held tick: one pop only
        do_reset(2);
        check("overflow_cleared", overflow, 1'b0);
        push_val(41); push_val(43);
        snap = ov_count;
        for (int i = 0; i < 100; i++) drive_cycle(1'b1, 1'b0, '0);
        idle(10);
        check("held_tick_one_valid", ov_count - snap, 1);
        check("held_tick_level", fifo_level, 1);
        tick_and_wait();

        // Fill beyond DEPTH
        do_reset(2);
        for (int i = 0; i <= DEPTH; i++) push_val(DATA_W'(100 + i));
        check("full_level", fifo_level, DEPTH);
        check("full_in_ready", in_ready, 1'b0);
        drive_cycle(1'b1, 1'b1, 200);
        idle(1);
        check("full_pop_no_push", fifo_level, DEPTH - 1);
        idle(28);
        for (int i = 0; i < DEPTH; i++) tick_and_wait();
        check("full_drained", fifo_level, 0);

        // Reset during SHIFT
        for (int i = 0; i < 4; i++) push_val(DATA_W'(301 + i));
        drive_cycle(1'b1, 1'b0, '0);
        idle(9);
        check("pre_reset_level", fifo_level, 3);
        do_reset(1);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_bcd", bcd_out, 24'd0);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_ready", in_ready, 1'b1);
        idle(30);

        check("pending_outputs", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prime_pacer.md
PRIME_PACER -- requirements
Module: prime_pacer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in entries; power of two, 2..64.
REQ-002 Parameter DATA_W, default 20, width of the binary input value.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream (sieve reader) presents a prime on in_data.
REQ-006 in_data  input  DATA_W  binary prime value.
REQ-007 in_ready  output  1  FIFO can accept; transfer when in_valid && in_ready.
REQ-008 tick  input  1  pacing strobe from the 1-second timer; level or pulse tolerated.
REQ-009 pause  input  1  high = hold current display, do not pop.
REQ-010 bcd_out  output  24  six BCD digits, digit 0 in [3:0]; feeds per-digit 7-seg decoders.
REQ-011 digit_en  output  6  per-digit enable; feeds the display driver valid input.
REQ-012 out_valid  output  1  one-cycle pulse when bcd_out/digit_en update.
REQ-013 overflow  output  1  sticky: a popped value exceeded 999999.
REQ-014 fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 FIFO: in_ready = (fifo_level != DEPTH), derived from registered state only; push when full is never accepted, even in a pop cycle.
REQ-016 Simultaneous push and pop on a non-full, non-empty FIFO leaves fifo_level unchanged; pointers wrap modulo DEPTH.
REQ-017 Tick event = tick high this cycle and low the previous cycle (registered edge detect); a tick held high yields exactly one event.
REQ-018 On a tick event with FIFO non-empty, converter IDLE and pause low, head entry pops and conversion starts.
REQ-019 Tick event while empty, busy or paused is discarded, not queued.
REQ-020 Converter FSM states: IDLE, SHIFT, DONE; IDLE->SHIFT on pop; SHIFT for exactly DATA_W cycles; SHIFT->DONE; DONE->IDLE after one cycle.
REQ-021 SHIFT cycle: each BCD digit >=5 gets +3, then {digits, value} shifts left one bit, input MSB first.
REQ-022 DONE registers bcd_out and digit_en and pulses out_valid in the following cycle.
REQ-023 Latency: tick event sampled in cycle T -> out_valid high in cycle T+DATA_W+2 only (T+22 at default).
REQ-024 bcd_out, digit_en hold their values between updates.
REQ-025 Popped value > 999999: bcd_out = 24'h999999, overflow set, held until reset.
REQ-026 pause asserted mid-conversion does not abort it; the result still lands.

Reset
REQ-027 rst high: FIFO emptied (fifo_level = 0, in_ready = 1), FSM to IDLE, any conversion aborted with no out_valid.
REQ-028 Reset values: bcd_out = 0, out_valid = 0, overflow = 0, tick edge register = 1 (a tick high at reset release is not an event).
REQ-029 digit_en reset value: 6'b000001 with the feature in REQ-030 compiled in, 6'b111111 without.

Configuration
REQ-030 Macro PRIME_PACER_LZ_BLANK_EN defined: digit_en[i] = 1 iff any digit at index >= i is nonzero; digit_en[0] always 1.
REQ-031 Macro undefined: digit_en = 6'b111111 always; leading zeros displayed.

Verification
REQ-032 Push 2,3,5; three tick pulses 30 cycles apart -> bcd_out 000002, 000003, 000005; out_valid 22 cycles after each tick.
REQ-033 Push DEPTH+1 values with no ticks -> in_ready low after DEPTH pushes, fifo_level = DEPTH, extra value not stored.
REQ-034 Tick held high 100 cycles with 2 entries queued -> exactly one pop, one out_valid.
REQ-035 Push 999983 then 1048575 and tick twice -> bcd_out 999983, then 999999 with overflow = 1 sticky.
REQ-036 Push 97, LZ_BLANK_EN defined -> digit_en = 6'b000011; undefined -> 6'b111111.
REQ-037 rst in cycle 10 of SHIFT with 3 queued -> no out_valid, fifo_level = 0, bcd_out = 0 next cycle.
